// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Scoreboard entries mirror the datapath pipeline registers.
package pipe_pkg;

    localparam int MAX_AW = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] dst;
        logic              wr;
        logic              ld;
    } sb_entry_t;

    // E-stage select code for the write-back result
    function automatic int FWD_W(input int loadLat);
        return loadLat + 1;
    endfunction

    // Register 0 is hard-wired, so it never creates a dependency
    function automatic logic match(input sb_entry_t e, input logic [MAX_AW-1:0] r);
        return e.valid && e.wr && (e.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/pipe_sb_stage.sv
// One scoreboard register: holds when en is low, loads a bubble on clr.
// The datapath never flushes and holds the same stage together.
module pipe_sb_stage
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      clr,
    input  sb_entry_t d,
    output sb_entry_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for a pipeline with LOAD_LAT memory
// stages and multi-cycle execute ops. All outputs are combinational.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MC_W     = 6,
    parameter int FW       = $clog2(LOAD_LAT + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_valid,
    input  logic [AW-1:0]   d_rs,
    input  logic [AW-1:0]   d_rt,
    input  logic            d_use_rs,
    input  logic            d_use_rt,
    input  logic            d_branch,
    input  logic            d_redirect,
    input  logic [AW-1:0]   d_dst,
    input  logic            d_reg_write,
    input  logic            d_mem_to_reg,
    input  logic [MC_W-1:0] d_mc_cycles,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            stall_e,
    output logic            flush_m,
    output logic [FW-1:0]   fwd_a_d,
    output logic [FW-1:0]   fwd_b_d,
    output logic [FW-1:0]   fwd_a_e,
    output logic [FW-1:0]   fwd_b_e,
    output logic            mc_busy
);

    // Entry index doubles as the E forward code: 0 = E, k = Mk, LOAD_LAT+1 = W
    localparam int NS = LOAD_LAT + 2;
    localparam int WB = LOAD_LAT + 1;

    sb_entry_t sbD [NS];
    sb_entry_t sbQ [NS];
    logic      stageEn [NS];
    logic      stageClr [NS];

    logic [AW-1:0]   eRs, eRt;
    logic            eUseRs, eUseRt;
    logic [MC_W-1:0] mcCount;

    logic              mcBusy, luStall, brStall, hzStall;
    logic              luRs, luRt, brRs, brRt;
    logic [MAX_AW-1:0] rsW, rtW, eRsW, eRtW;
    sb_entry_t         dEntry;

    assign rsW  = MAX_AW'(d_rs);
    assign rtW  = MAX_AW'(d_rt);
    assign eRsW = MAX_AW'(eRs);
    assign eRtW = MAX_AW'(eRt);

    always_comb begin
        dEntry       = '0;
        dEntry.valid = d_valid;
        dEntry.dst   = MAX_AW'(d_dst);
        dEntry.wr    = d_reg_write;
        dEntry.ld    = d_mem_to_reg;
    end

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            sbD[s]      = '0;
            stageEn[s]  = 1'b1;
            stageClr[s] = 1'b0;
        end
        sbD[0]      = dEntry;
        stageEn[0]  = ~stall_e;
        stageClr[0] = flush_e;
        stageClr[1] = flush_m;
        for (int s = 1; s < NS; s++) begin
            sbD[s] = sbQ[s-1];
        end
    end

    for (genvar s = 0; s < NS; s++) begin : gStage
        pipe_sb_stage uStage (
            .clk (clk),
            .rst (rst),
            .en  (stageEn[s]),
            .clr (stageClr[s]),
            .d   (sbD[s]),
            .q   (sbQ[s])
        );
    end

    // E-only fields follow the E entry's hold/flush; the counter runs down while held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eRs     <= '0;
            eRt     <= '0;
            eUseRs  <= 1'b0;
            eUseRt  <= 1'b0;
            mcCount <= '0;
        end else if (stall_e) begin
            mcCount <= mcCount - MC_W'(1);
        end else if (flush_e) begin
            eRs     <= '0;
            eRt     <= '0;
            eUseRs  <= 1'b0;
            eUseRt  <= 1'b0;
            mcCount <= '0;
        end else begin
            eRs     <= d_rs;
            eRt     <= d_rt;
            eUseRs  <= d_use_rs;
            eUseRt  <= d_use_rt;
            mcCount <= (d_valid && d_mc_cycles >= MC_W'(2)) ? d_mc_cycles - MC_W'(1) : '0;
        end
    end

    // Walk M stages far to near so the nearest source wins
    always_comb begin
        luRs    = 1'b0;
        luRt    = 1'b0;
        brRs    = 1'b0;
        brRt    = 1'b0;
        fwd_a_d = FW'(FWD_RF);
        fwd_b_d = FW'(FWD_RF);
        fwd_a_e = FW'(FWD_RF);
        fwd_b_e = FW'(FWD_RF);

        if (match(sbQ[0], rsW)) begin
            luRs = sbQ[0].ld;
            brRs = 1'b1;
        end
        if (match(sbQ[0], rtW)) begin
            luRt = sbQ[0].ld;
            brRt = 1'b1;
        end

        for (int k = LOAD_LAT; k >= 1; k--) begin
            if (match(sbQ[k], rsW)) begin
                if (sbQ[k].ld) begin
                    brRs = 1'b1;
                    if (k < LOAD_LAT) luRs = 1'b1;
                end else if (d_valid && d_use_rs) begin
                    fwd_a_d = FW'(k);
                end
            end
            if (match(sbQ[k], rtW)) begin
                if (sbQ[k].ld) begin
                    brRt = 1'b1;
                    if (k < LOAD_LAT) luRt = 1'b1;
                end else if (d_valid && d_use_rt) begin
                    fwd_b_d = FW'(k);
                end
            end
        end

        for (int k = WB; k >= 1; k--) begin
            if (sbQ[0].valid && eUseRs && match(sbQ[k], eRsW) && (k == WB || !sbQ[k].ld)) begin
                fwd_a_e = (k == WB) ? FW'(FWD_W(LOAD_LAT)) : FW'(k);
            end
            if (sbQ[0].valid && eUseRt && match(sbQ[k], eRtW) && (k == WB || !sbQ[k].ld)) begin
                fwd_b_e = (k == WB) ? FW'(FWD_W(LOAD_LAT)) : FW'(k);
            end
        end
    end

    assign mcBusy  = (mcCount != '0);
    assign luStall = d_valid & ((d_use_rs & luRs) | (d_use_rt & luRt));
    assign brStall = d_valid & d_branch & ((d_use_rs & brRs) | (d_use_rt & brRt));
    assign hzStall = luStall | brStall;

    // A busy multi-cycle op freezes E, so it masks the bubble the hazards would insert
    assign mc_busy = mcBusy;
    assign stall_e = mcBusy;
    assign flush_m = mcBusy;
    assign stall_f = mcBusy | hzStall;
    assign stall_d = mcBusy | hzStall;
    assign flush_e = hzStall & ~mcBusy;
    assign flush_d = d_redirect & ~stall_d;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances
// share the D-stage stimulus; expected output vectors are queued per cycle.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, dst;
        logic       urs, urt, br, rd, wr, ld;
        logic [5:0] mc;
    } instr_t;

    // Flag order: stall_f stall_d flush_d flush_e stall_e flush_m mc_busy
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] HZ   = 7'b1101000;
    localparam logic [6:0] MC   = 7'b1100111;
    localparam logic [6:0] FD   = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_valid, d_use_rs, d_use_rt, d_branch, d_redirect, d_reg_write, d_mem_to_reg;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [5:0] d_mc_cycles;

    logic       o1StallF, o1StallD, o1FlushD, o1FlushE, o1StallE, o1FlushM, o1Busy;
    logic [1:0] o1FadD, o1FbdD, o1FaeE, o1FbeE;
    logic       o3StallF, o3StallD, o3FlushD, o3FlushE, o3StallE, o3FlushM, o3Busy;
    logic [2:0] o3FadD, o3FbdD, o3FaeE, o3FbeE;

    logic [18:0] exp_q[$];
    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(5), .LOAD_LAT(1), .MC_W(6)) u1 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_branch(d_branch),
        .d_redirect(d_redirect), .d_dst(d_dst), .d_reg_write(d_reg_write),
        .d_mem_to_reg(d_mem_to_reg), .d_mc_cycles(d_mc_cycles),
        .stall_f(o1StallF), .stall_d(o1StallD), .flush_d(o1FlushD), .flush_e(o1FlushE),
        .stall_e(o1StallE), .flush_m(o1FlushM), .fwd_a_d(o1FadD), .fwd_b_d(o1FbdD),
        .fwd_a_e(o1FaeE), .fwd_b_e(o1FbeE), .mc_busy(o1Busy)
    );

    pipe_hazard_ctrl #(.AW(5), .LOAD_LAT(3), .MC_W(6)) u3 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_branch(d_branch),
        .d_redirect(d_redirect), .d_dst(d_dst), .d_reg_write(d_reg_write),
        .d_mem_to_reg(d_mem_to_reg), .d_mc_cycles(d_mc_cycles),
        .stall_f(o3StallF), .stall_d(o3StallD), .flush_d(o3FlushD), .flush_e(o3FlushE),
        .stall_e(o3StallE), .flush_m(o3FlushM), .fwd_a_d(o3FadD), .fwd_b_d(o3FbdD),
        .fwd_a_e(o3FaeE), .fwd_b_e(o3FbeE), .mc_busy(o3Busy)
    );

    function automatic logic [18:0] obs1();
        return {o1StallF, o1StallD, o1FlushD, o1FlushE, o1StallE, o1FlushM, o1Busy,
                3'(o1FadD), 3'(o1FbdD), 3'(o1FaeE), 3'(o1FbeE)};
    endfunction

    function automatic logic [18:0] obs3();
        return {o3StallF, o3StallD, o3FlushD, o3FlushE, o3StallE, o3FlushM, o3Busy,
                o3FadD, o3FbdD, o3FaeE, o3FbeE};
    endfunction

    function automatic logic [18:0] ex(input logic [6:0] fl, input int fad, input int fbd,
                                       input int fae, input int fbe);
        return {fl, 3'(fad), 3'(fbd), 3'(fae), 3'(fbe)};
    endfunction

    function automatic instr_t nop();
        instr_t i = '{v: 1'b0, rs: 5'd0, rt: 5'd0, dst: 5'd0, urs: 1'b0, urt: 1'b0,
                      br: 1'b0, rd: 1'b0, wr: 1'b0, ld: 1'b0, mc: 6'd0};
        return i;
    endfunction

    function automatic instr_t alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        instr_t i = nop();
        i.v = 1'b1; i.dst = dst; i.rs = rs; i.rt = rt;
        i.urs = 1'b1; i.urt = 1'b1; i.wr = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw(input logic [4:0] dst, input logic [4:0] base);
        instr_t i = nop();
        i.v = 1'b1; i.dst = dst; i.rs = base; i.urs = 1'b1; i.wr = 1'b1; i.ld = 1'b1;
        return i;
    endfunction

    function automatic instr_t beq(input logic [4:0] rs, input logic [4:0] rt, input logic taken);
        instr_t i = nop();
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.urs = 1'b1; i.urt = 1'b1;
        i.br = 1'b1; i.rd = taken;
        return i;
    endfunction

    function automatic instr_t mcop(input logic [4:0] dst, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [5:0] n);
        instr_t i = alu(dst, rs, rt);
        i.mc = n;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        d_valid      = i.v;
        d_rs         = i.rs;
        d_rt         = i.rt;
        d_use_rs     = i.urs;
        d_use_rt     = i.urt;
        d_branch     = i.br;
        d_redirect   = i.rd;
        d_dst        = i.dst;
        d_reg_write  = i.wr;
        d_mem_to_reg = i.ld;
        d_mc_cycles  = i.mc;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(nop());
        end
    endtask

    task automatic test_reset();
        logic [18:0] got;
        logic [18:0] want;
        drive(nop());
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(ex(NONE, 0, 0, 0, 0));
        exp_q.push_back(ex(NONE, 0, 0, 0, 0));
        #1;
        got = obs1(); want = exp_q.pop_front(); nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL reset_u1: got %b want %b", got, want);
        end
        got = obs3(); want = exp_q.pop_front(); nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL reset_u3: got %b want %b", got, want);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_m1_forward();
        instr_t      prog[4];
        logic [18:0] exv[4];
        logic [18:0] got;
        logic [18:0] want;
        logic [4:0]  a, b;
        a = 5'($urandom_range(1, 31));
        b = 5'($urandom_range(1, 31));
        prog[0] = alu(a, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        prog[1] = alu(b, a, a);
        prog[2] = nop();
        prog[3] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(NONE, 0, 0, 0, 0);
        exv[2] = ex(NONE, 0, 0, 1, 1);
        exv[3] = ex(NONE, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL m1_forward step %0d (r%0d): got %b want %b", i, a, got, want);
            end
        end
    endtask

    task automatic test_load_use_1();
        instr_t      prog[4];
        logic [18:0] exv[4];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = lw(5'd2, 5'd5);
        prog[1] = alu(5'd3, 5'd2, 5'd0);
        prog[2] = alu(5'd3, 5'd2, 5'd0);
        prog[3] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(HZ, 0, 0, 0, 0);
        exv[2] = ex(NONE, 0, 0, 0, 0);
        exv[3] = ex(NONE, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL load_use_lat1 step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use_3();
        instr_t      prog[6];
        logic [18:0] exv[6];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = lw(5'd2, 5'd5);
        for (int i = 1; i < 5; i++) prog[i] = alu(5'd3, 5'd2, 5'd0);
        prog[5] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(HZ, 0, 0, 0, 0);
        exv[2] = ex(HZ, 0, 0, 0, 0);
        exv[3] = ex(HZ, 0, 0, 0, 0);
        exv[4] = ex(NONE, 0, 0, 0, 0);
        exv[5] = ex(NONE, 0, 0, 4, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs3(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL load_use_lat3 step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        instr_t      prog[4];
        logic [18:0] exv[4];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = alu(5'd4, 5'd1, 5'd2);
        prog[1] = beq(5'd4, 5'd0, 1'b1);
        prog[2] = beq(5'd4, 5'd0, 1'b1);
        prog[3] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(HZ, 0, 0, 0, 0);
        exv[2] = ex(FD, 1, 0, 0, 0);
        exv[3] = ex(NONE, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL branch step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_multi_cycle();
        instr_t      prog[6];
        logic [18:0] exv[6];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = mcop(5'd6, 5'd1, 5'd2, 6'd4);
        for (int i = 1; i < 5; i++) prog[i] = alu(5'd7, 5'd6, 5'd0);
        prog[5] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(MC, 0, 0, 0, 0);
        exv[2] = ex(MC, 0, 0, 0, 0);
        exv[3] = ex(MC, 0, 0, 0, 0);
        exv[4] = ex(NONE, 0, 0, 0, 0);
        exv[5] = ex(NONE, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL multi_cycle step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        instr_t      prog[6];
        logic [18:0] exv[6];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = mcop(5'd8, 5'd1, 5'd2, 6'd3);
        prog[1] = mcop(5'd9, 5'd3, 5'd4, 6'd2);
        prog[2] = prog[1];
        prog[3] = prog[1];
        prog[4] = nop();
        prog[5] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(MC, 0, 0, 0, 0);
        exv[2] = ex(MC, 0, 0, 0, 0);
        exv[3] = ex(NONE, 0, 0, 0, 0);
        exv[4] = ex(MC, 0, 0, 0, 0);
        exv[5] = ex(NONE, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        instr_t      prog[6];
        logic [18:0] exv[6];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = mcop(5'd6, 5'd1, 5'd2, 6'd5);
        prog[1] = nop();
        prog[2] = nop();
        prog[3] = alu(5'd1, 5'd2, 5'd3);
        prog[4] = alu(5'd2, 5'd1, 5'd1);
        prog[5] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(MC, 0, 0, 0, 0);
        exv[2] = ex(MC, 0, 0, 0, 0);
        exv[3] = ex(NONE, 0, 0, 0, 0);
        exv[4] = ex(NONE, 0, 0, 0, 0);
        exv[5] = ex(NONE, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL reset_mid_op step %0d: got %b want %b", i, got, want);
            end
            if (i == 2) begin
                #1 rst = 1'b0;
                exp_q.push_back(ex(NONE, 0, 0, 0, 0));
                #1;
                got = obs1(); want = exp_q.pop_front(); nChecks++;
                if (got !== want) begin
                    nFail++;
                    $display("FAIL reset_mid_op async: got %b want %b", got, want);
                end
                @(negedge clk);
                rst = 1'b1;
            end
        end
    endtask

    task automatic test_reg_zero();
        instr_t      prog[5];
        logic [18:0] exv[5];
        logic [18:0] got;
        logic [18:0] want;
        prog[0] = alu(5'd0, 5'd1, 5'd2);
        prog[1] = alu(5'd3, 5'd0, 5'd0);
        prog[2] = lw(5'd0, 5'd5);
        prog[3] = beq(5'd0, 5'd0, 1'b1);
        prog[4] = nop();
        exv[0] = ex(NONE, 0, 0, 0, 0);
        exv[1] = ex(NONE, 0, 0, 0, 0);
        exv[2] = ex(NONE, 0, 0, 0, 0);
        exv[3] = ex(FD, 0, 0, 0, 0);
        exv[4] = ex(NONE, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(prog[i]);
            exp_q.push_back(exv[i]);
            #1;
            got = obs1(); want = exp_q.pop_front(); nChecks++;
            if (got !== want) begin
                nFail++;
                $display("FAIL reg_zero step %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        drive(nop());
        test_reset();
        drain();
        test_m1_forward();
        drain();
        test_load_use_1();
        drain();
        test_load_use_3();
        drain();
        test_branch();
        drain();
        test_multi_cycle();
        drain();
        test_back_to_back();
        drain();
        test_reset_mid_op();
        drain();
        test_reg_zero();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the five-stage MIPS pipeline, generalised to a configurable number of memory stages and multi-cycle execute ops. It replaces the fixed single-M-stage hazard logic in the datapath. It holds its own scoreboard of the in-flight E/M/W instructions, mirroring the datapath pipeline registers. From that scoreboard and the decode-stage request it drives every stall, flush and forward select.

## Interface
- `AW`, 5: register address width.
- `LOAD_LAT`, 1: number of M stages (M1..M`LOAD_LAT`), range 1..4. Load data is valid only from W.
- `MC_W`, 6: width of the multi-cycle count.
- `FW`, derived, $clog2(LOAD_LAT+2): forward-select width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `d_valid`  in  1  D holds a real instruction.
- `d_rs`, `d_rt`  in  AW  source registers.
- `d_use_rs`, `d_use_rt`  in  1  operand actually read.
- `d_branch`  in  1  branch compare in D.
- `d_redirect`  in  1  branch taken or jump resolved in D.
- `d_dst`  in  AW  destination register.
- `d_reg_write`, `d_mem_to_reg`  in  1  writes reg / is a load.
- `d_mc_cycles`  in  MC_W  E-stage occupancy; 0 or 1 means single-cycle.
- `stall_f`, `stall_d`  out  1  hold PC / hold the D register.
- `flush_d`  out  1  clear the D register (kill the fetched instruction).
- `flush_e`  out  1  insert a bubble into E.
- `stall_e`  out  1  hold the E register (multi-cycle op busy).
- `flush_m`  out  1  insert a bubble into M1.
- `fwd_a_d`, `fwd_b_d`  out  FW  D compare operand: 0 = regfile, k = M stage k ALU result.
- `fwd_a_e`, `fwd_b_e`  out  FW  E operand: 0 = regfile, k = Mk ALU result (1..LOAD_LAT), LOAD_LAT+1 = W result.
- `mc_busy`  out  1  multi-cycle op in progress.

## Operation
- **Scoreboard.** Entries are E, M1..M`LOAD_LAT`, W. Each entry holds {valid, dst, wr, ld}; E also holds rs, rt, use flags and the mc count.
- **Match.** An entry matches source register r when valid & wr & dst==r & r!=0. Register 0 never causes a hazard.
- **E forwarding.** Priority is nearest first: M1 > … > M`LOAD_LAT` > W.
  - A matching M entry with ld=1 is not a forward source, because the load is still in flight.
  - Load-use stalls guarantee this case never reaches E.
- **D forwarding (branch).** Source is the nearest matching non-load M entry. W is never a D source because the regfile writes through on the falling clock edge.
- **Load-use stall.** Condition: D uses r, and a matching load sits in E or in M1..M(`LOAD_LAT`-1).
  - Response: stall_f = stall_d = flush_e = 1.
- **Branch stall.** Condition: d_branch, and a used source matches any writer in E or any load in M1..M`LOAD_LAT`.
  - Response: same outputs as the load-use stall.
- **Redirect.** flush_d = d_redirect & ~stall_d. An unresolved branch never flushes.
- **Multi-cycle op.** When an op with N = d_mc_cycles ≥ 2 enters E, the counter loads N-1.
  - While the counter ≠ 0: mc_busy = stall_e = stall_d = stall_f = flush_m = 1, and flush_e = 0. The counter decrements each cycle.
  - The op leaves E on the cycle the counter is 0.
- **Priority.** mc_busy overrides the load-use and branch stalls. flush_e is 0 while stall_e is high.
- **Advance.** Shadow entries advance with the same stall/flush rules as the datapath.
  - A flushed stage loads valid=0.
  - A held stage keeps its contents.

## Timing
- All outputs are combinational from scoreboard state plus the D inputs. There are no output registers, so latency is 0 cycles.
- **Reset.** Asserting `rst` low asynchronously clears all valid bits and the mc counter. All outputs read 0 in the same cycle and stay 0 until the first valid instruction arrives.
- **Load-use cost.**
  - Load in E: `LOAD_LAT` stall cycles.
  - Load in Mk: `LOAD_LAT`-k stall cycles.
  - After the stall the consumer forwards from W.
- **Multi-cycle cost.** N-1 stall cycles. Back-to-back multi-cycle ops reload the counter on the first cycle of the second op in E.
- **Hold-over.** A D instruction held by a stall re-evaluates its hazards each cycle. Its outputs follow the current state.

## Structure
- **Package `pipe_pkg`:**
  - forward-select constants (FWD_RF=0, FWD_W(LOAD_LAT) function);
  - `sb_entry_t` struct {valid, dst, wr, ld};
  - the `match()` function.
- **Sub-module `pipe_sb_stage`:** one scoreboard register with en (~hold), clr (flush) and async active-low reset. It is instantiated for E, M1..M`LOAD_LAT` and W via a generate loop.
- **Top level:** holds the mc counter, the priority encoders and the stall logic.

## Test plan
- **M1 forward.** LOAD_LAT=1; add r1 followed by add r2,r1,r1. The consumer's E cycle shows fwd_a_e=fwd_b_e=1 and no stall.
- **Load-use, LOAD_LAT=1.** lw r2 followed by add r3,r2,r0. One cycle of stall_f=stall_d=flush_e=1, then fwd_a_e=2 (W).
- **Load-use, LOAD_LAT=3.** Same sequence gives 3 stall cycles, then fwd_a_e=4.
- **Branch on fresh result.** add r4 followed by beq r4,r0 taken.
  - 1 stall cycle, then fwd_a_d=1 and flush_d=1 for exactly one cycle.
  - During the stall flush_d=0.
- **Multi-cycle op.** mc op with d_mc_cycles=4.
  - stall_e=flush_m=mc_busy=1 for 3 cycles, flush_e=0 throughout.
  - A dependent add next gets fwd=1 on the following cycle.
- **Reset mid-op and register 0.**
  - Assert rst low during the mc count. All outputs go to 0 immediately, and after release the pipeline restarts clean.
  - A write to r0 followed by a read of r0 produces no forward and no stall.
